// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives J/K of an external JK flip-flop bank
// to run LOAD, CLEAR, COUNT_UP and TOGGLE_MASK commands.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_COUNT  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    state_t             state;
    state_t             nxt;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   data_r;
    logic [CNT_W-1:0]   rem;
    logic               live;
    logic               accept;
    logic               zero_len;
    logic               carry;

    assign accept   = cmd_valid & cmd_ready;
    assign zero_len = cmd_op[1] & (cmd_len == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // live holds cmd_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live   <= 1'b0;
            op_r   <= OP_LOAD;
            data_r <= '0;
            rem    <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
                rem    <= cmd_op[1] ? cmd_len : CNT_W'(1);
            end else if (state == EXEC) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) nxt = zero_len ? DONE : EXEC;
            end
            EXEC: begin
                if (rem == CNT_W'(1)) nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        j         = '0;
        k         = '0;
        done      = 1'b0;
        wrap      = 1'b0;
        carry     = 1'b1;
        cmd_ready = (state == IDLE) & live;
        busy      = (state != IDLE);
        unique case (state)
            EXEC: begin
                unique case (op_r)
                    OP_LOAD: begin
                        j = data_r;
                        k = ~data_r;
                    end
                    OP_CLEAR: begin
                        k = '1;
                    end
                    OP_COUNT: begin
                        // ripple the all-ones-below term as a carry chain
                        for (int i = 0; i < WIDTH; i++) begin
                            j[i]  = carry;
                            k[i]  = carry;
                            carry = carry & q[i];
                        end
                        wrap = &q;
                    end
                    OP_TOGGLE: begin
                        j = data_r;
                        k = data_r;
                    end
                endcase
            end
            DONE:    done = 1'b1;
            IDLE:    ;
            default: ;
        endcase
    end

endmodule
